// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mag_comparator
//  Purpose  : Bit-serial magnitude comparator. Operands a and b arrive one bit
//             pair per beat, MSB first, framed by in_first/in_last on a
//             valid/ready stream. One registered result (gt/lt/eq, frame
//             length, overflow flag) is presented per frame on a valid/ready
//             result port.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready, in_a, in_b, in_first, in_last  - input beats
//             res_valid/res_ready, res_gt, res_lt, res_eq,
//             res_len[LEN_W-1:0], res_err                         - result
//  Revision : 1.0 - initial release
// ============================================================================
module serial_mag_comparator #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_eq,
    output logic [LEN_W-1:0] res_len,
    output logic             res_err
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_cmp  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_count;
    logic             r_decided;
    logic             r_gt;
    logic             r_lt;
    logic             r_err;
    logic             r_in_ready;

    logic             w_accept;
    logic             w_take;
    logic [LEN_W-1:0] w_count_nxt;
    logic             w_decided_nxt;
    logic             w_gt_nxt;
    logic             w_lt_nxt;
    logic             w_err_nxt;

    assign in_ready = r_in_ready;
    assign w_accept = in_valid & r_in_ready;
    // In IDLE only a frame-start beat is meaningful; stray beats are consumed
    // and dropped. In CMP every accepted beat updates the frame.
    assign w_take   = w_accept & (in_first | (r_state == c_cmp));

    // Frame state after the current beat. A first beat always restarts the
    // frame, which also covers abandoning a frame in progress.
    always_comb begin
        w_count_nxt   = r_count;
        w_decided_nxt = r_decided;
        w_gt_nxt      = r_gt;
        w_lt_nxt      = r_lt;
        w_err_nxt     = r_err;
        if (in_first) begin
            w_count_nxt   = c_one;
            w_decided_nxt = in_a ^ in_b;
            w_gt_nxt      = in_a & ~in_b;
            w_lt_nxt      = ~in_a & in_b;
            w_err_nxt     = 1'b0;
        end else if (r_count < c_max_len) begin
            w_count_nxt = r_count + c_one;
            // MSB first: only the first differing bit decides the outcome.
            if (!r_decided && (in_a ^ in_b)) begin
                w_decided_nxt = 1'b1;
                w_gt_nxt      = in_a & ~in_b;
                w_lt_nxt      = ~in_a & in_b;
            end
        end else begin
            // Beat beyond MAX_LEN: bit ignored, frame flagged.
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_count    <= '0;
            r_decided  <= 1'b0;
            r_gt       <= 1'b0;
            r_lt       <= 1'b0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_gt     <= 1'b0;
            res_lt     <= 1'b0;
            res_eq     <= 1'b0;
            res_len    <= '0;
            res_err    <= 1'b0;
        end else begin
            case (r_state)
                c_idle, c_cmp: begin
                    r_in_ready <= 1'b1;
                    if (w_take) begin
                        r_count   <= w_count_nxt;
                        r_decided <= w_decided_nxt;
                        r_gt      <= w_gt_nxt;
                        r_lt      <= w_lt_nxt;
                        r_err     <= w_err_nxt;
                        if (in_last) begin
                            // Result is loaded straight from the final beat so
                            // it is valid right after the edge that took it.
                            r_state    <= c_done;
                            r_in_ready <= 1'b0;
                            res_valid  <= 1'b1;
                            res_gt     <= w_gt_nxt;
                            res_lt     <= w_lt_nxt;
                            res_eq     <= ~w_decided_nxt;
                            res_len    <= w_count_nxt;
                            res_err    <= w_err_nxt;
                        end else begin
                            r_state <= c_cmp;
                        end
                    end
                end
                c_done: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        r_state    <= c_idle;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_idle;
                    r_in_ready <= 1'b1;
                    res_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_mag_comparator
//  Purpose  : Self-checking bench for serial_mag_comparator. Directed and
//             randomized frames are compared against an arithmetic reference
//             model of the comparison (integer compare of the first MAX_LEN
//             bits of each operand).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mag_comparator;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_a;
    logic             in_b;
    logic             in_first;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic             res_gt;
    logic             res_lt;
    logic             res_eq;
    logic [LEN_W-1:0] res_len;
    logic             res_err;

    int vectors     = 0;
    int miscompares = 0;

    serial_mag_comparator #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_gt    (res_gt),
        .res_lt    (res_lt),
        .res_eq    (res_eq),
        .res_len   (res_len),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: compare the first min(n, MAX_LEN) bits as unsigned integers.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input int n,
                                      output logic gt, output logic lt, output logic eq,
                                      output logic [31:0] len, output logic err);
        int          m;
        logic [63:0] av;
        logic [63:0] bv;
        m   = (n > MAX_LEN) ? MAX_LEN : n;
        av  = ({32'd0, a} & ((64'd1 << n) - 64'd1)) >> (n - m);
        bv  = ({32'd0, b} & ((64'd1 << n) - 64'd1)) >> (n - m);
        gt  = av > bv;
        lt  = av < bv;
        eq  = av == bv;
        len = 32'(m);
        err = n > MAX_LEN;
    endfunction

    // Called at a point just after a rising edge; returns just after the
    // edge that accepted the beat. Data lines carry junk while invalid.
    task automatic beat(input logic a, input logic b, input logic first, input logic last);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = 1'($urandom);
        in_b     = 1'($urandom);
        in_first = 1'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            beat(a[i], b[i], i == n - 1, i == 0);
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (!res_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input int n, input bit backpressure);
        logic        gt, lt, eq, err;
        logic [31:0] len;
        ref_model(a, b, n, gt, lt, eq, len, err);
        wait_result();
        chk({tag, "_gt"},  32'(res_gt),  32'(gt));
        chk({tag, "_lt"},  32'(res_lt),  32'(lt));
        chk({tag, "_eq"},  32'(res_eq),  32'(eq));
        chk({tag, "_len"}, 32'(res_len), len);
        chk({tag, "_err"}, 32'(res_err), 32'(err));
        if (backpressure) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        accept_result();
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          rn;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 1'b0;
        in_b      = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_gt",    32'(res_gt),    32'd0);
        chk("rst_res_lt",    32'(res_lt),    32'd0);
        chk("rst_res_eq",    32'(res_eq),    32'd0);
        chk("rst_res_len",   32'(res_len),   32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Exhaustive 2-bit sweep, no backpressure
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                send_frame(32'(a), 32'(b), 2, 1'b0);
                expect_frame("sweep2", 32'(a), 32'(b), 2, 1'b0);
            end
        end

        // 16-bit directed frames
        send_frame(32'h8000, 32'h7FFF, 16, 1'b0);
        expect_frame("w16_gt", 32'h8000, 32'h7FFF, 16, 1'b0);
        send_frame(32'h1234, 32'h1234, 16, 1'b0);
        expect_frame("w16_eq", 32'h1234, 32'h1234, 16, 1'b0);
        send_frame(32'h00FF, 32'h0100, 16, 1'b0);
        expect_frame("w16_lt", 32'h00FF, 32'h0100, 16, 1'b0);

        // Single-bit frame, then 5 cycles of result backpressure with a beat offered
        beat(1'b1, 1'b0, 1'b1, 1'b1);
        chk("single_latency", 32'(res_valid), 32'd1);
        chk("single_gt",      32'(res_gt),    32'd1);
        chk("single_len",     32'(res_len),   32'd1);
        in_valid = 1'b1; in_a = 1'b0; in_b = 1'b1; in_first = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_gt",    32'(res_gt),    32'd1);
            chk("hold_res_len",   32'(res_len),   32'd1);
        end
        in_valid = 1'b0;
        accept_result();
        for (int i = 0; i < 3; i++) begin
            chk("hold_beat_not_consumed", 32'(res_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Restart: 5 beats of an abandoned frame, then a 3-bit frame 011 vs 010
        beat(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'($urandom), 1'($urandom), 1'b0, 1'b0);
        send_frame(32'h3, 32'h2, 3, 1'b0);
        expect_frame("restart", 32'h3, 32'h2, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("restart_single_result", 32'(res_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Overflow: 16 identical bits then a=1,b=0 on beat 17
        ra = $urandom & 32'hFFFF;
        send_frame({ra[15:0], 1'b1}, {ra[15:0], 1'b0}, 17, 1'b0);
        expect_frame("overflow", {ra[15:0], 1'b1}, {ra[15:0], 1'b0}, 17, 1'b0);

        // Randomized frames with input gaps and result backpressure
        for (int k = 0; k < 40; k++) begin
            rn = $urandom_range(1, 20);
            ra = $urandom;
            rb = ra;
            if ($urandom_range(0, 3) != 0) rb[$urandom_range(0, rn - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) rb = $urandom;
            send_frame(ra, rb, rn, 1'b1);
            expect_frame("random", ra, rb, rn, 1'b1);
        end

        // Asynchronous reset mid-frame (after beat 3)
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_rst_in_ready",  32'(in_ready),  32'd0);
        chk("midframe_rst_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while a result is pending
        send_frame(32'h1, 32'h0, 2, 1'b0);
        wait_result();
        #2 rst_n = 1'b0;
        #1;
        chk("done_rst_res_valid", 32'(res_valid), 32'd0);
        chk("done_rst_res_gt",    32'(res_gt),    32'd0);
        chk("done_rst_res_len",   32'(res_len),   32'd0);
        chk("done_rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_stale", 32'(res_valid), 32'd0);

        send_frame(32'h2, 32'h3, 2, 1'b0);
        expect_frame("after_rst", 32'h2, 32'h3, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("after_rst_single_result", 32'(res_valid), 32'd0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
